// File: rtl/dram_access_arbiter_if.sv
// DRAM burst command channel between the access arbiter and the DRAM master adapter.
interface dram_access_arbiter_if #(
    parameter int unsigned DRAM_ADDR_WIDTH = 39
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_rnw;
    logic [DRAM_ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]                 cmd_len;
    logic                       cmd_done;

    // Arbiter side: issues commands, observes acceptance and completion.
    modport master (
        output cmd_valid,
        output cmd_rnw,
        output cmd_addr,
        output cmd_len,
        input  cmd_ready,
        input  cmd_done
    );

    // DRAM adapter side.
    modport slave (
        input  cmd_valid,
        input  cmd_rnw,
        input  cmd_addr,
        input  cmd_len,
        output cmd_ready,
        output cmd_done
    );
endinterface

// File: rtl/dram_access_arbiter.sv
// Shares the DRAM burst command port between the upload write path and the display
// refill read path. One latched request per requester, urgent-read priority otherwise
// round-robin, one burst in flight at a time with a completion timeout.
module dram_access_arbiter #(
    parameter int unsigned DRAM_ADDR_WIDTH = 39,
    parameter int unsigned DRAM_DATA_WIDTH = 128,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,

    input  logic                       rd_req_en,
    input  logic [DRAM_ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [7:0]                 rd_req_len,
    input  logic                       rd_urgent,
    output logic                       rd_busy,

    input  logic                       wr_req_en,
    input  logic [DRAM_ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [7:0]                 wr_req_len,
    output logic                       wr_busy,

    dram_access_arbiter_if.master      cmd,

    input  logic                       clear_err,
    output logic                       req_drop_err,
    output logic                       timeout_err
);

    localparam int unsigned ALIGN_BITS = $clog2(DRAM_DATA_WIDTH / 8);
    localparam logic [DRAM_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((DRAM_ADDR_WIDTH'(1) << ALIGN_BITS) - DRAM_ADDR_WIDTH'(1));
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                     state_q, state_d;
    logic                       rd_pending_q, wr_pending_q;
    logic [DRAM_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [7:0]                 rd_len_q, wr_len_q;
    logic                       grant_rd_q;       // requester owning the current burst
    logic                       last_grant_rd_q;  // reset to write so the first tie goes to read
    logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_q;
    logic [7:0]                 cmd_len_q;
    logic [TIMER_W-1:0]         timer_q;
    logic                       req_drop_err_q, timeout_err_q;

    logic grant_valid, grant_rd, do_grant, timeout_hit, accept, rd_drop, wr_drop;

    // Arbitration decision from registered pending flags; only acted on in StIdle.
    always_comb begin
        grant_valid = rd_pending_q | wr_pending_q;
        if (rd_pending_q && wr_pending_q) begin
            grant_rd = rd_urgent | ~last_grant_rd_q;
        end else begin
            grant_rd = rd_pending_q;
        end
        do_grant    = (state_q == StIdle) && grant_valid;
        accept      = (state_q == StIssue) && cmd.cmd_ready;
        timeout_hit = (state_q == StWait) && !cmd.cmd_done && (timer_q == TIMER_LAST);
        rd_drop     = rd_req_en & rd_busy;
        wr_drop     = wr_req_en & wr_busy;
    end

    // FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_valid) state_d = StIssue;
            StIssue: if (cmd.cmd_ready) state_d = StWait;
            StWait:  if (cmd.cmd_done || timeout_hit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: command port, busy flags and sticky errors.
    always_comb begin
        cmd.cmd_valid = (state_q == StIssue);
        cmd.cmd_rnw   = grant_rd_q;
        cmd.cmd_addr  = cmd_addr_q;
        cmd.cmd_len   = cmd_len_q;
        rd_busy       = rd_pending_q | ((state_q != StIdle) & grant_rd_q);
        wr_busy       = wr_pending_q | ((state_q != StIdle) & ~grant_rd_q);
        req_drop_err  = req_drop_err_q;
        timeout_err   = timeout_err_q;
    end

    // Request latches; a strobe is only taken while its requester is not busy.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_pending_q <= 1'b0;
            wr_pending_q <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            rd_len_q     <= '0;
            wr_len_q     <= '0;
        end else begin
            if (rd_req_en && !rd_busy) begin
                rd_pending_q <= 1'b1;
                rd_addr_q    <= rd_req_addr;
                rd_len_q     <= rd_req_len;
            end else if (do_grant && grant_rd) begin
                rd_pending_q <= 1'b0;
            end
            if (wr_req_en && !wr_busy) begin
                wr_pending_q <= 1'b1;
                wr_addr_q    <= wr_req_addr;
                wr_len_q     <= wr_req_len;
            end else if (do_grant && !grant_rd) begin
                wr_pending_q <= 1'b0;
            end
        end
    end

    // Grant bookkeeping and command fields, frozen from grant until the next grant.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            grant_rd_q      <= 1'b0;
            last_grant_rd_q <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_len_q       <= '0;
        end else if (do_grant) begin
            grant_rd_q      <= grant_rd;
            last_grant_rd_q <= grant_rd;
            cmd_addr_q      <= (grant_rd ? rd_addr_q : wr_addr_q) & ALIGN_MASK;
            cmd_len_q       <= grant_rd ? rd_len_q : wr_len_q;
        end
    end

    // Completion timer: cleared on command accept, counts while waiting for cmd_done.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            timer_q <= '0;
        end else if (accept) begin
            timer_q <= '0;
        end else if (state_q == StWait) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            req_drop_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            if (rd_drop || wr_drop) begin
                req_drop_err_q <= 1'b1;
            end else if (clear_err) begin
                req_drop_err_q <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end else if (clear_err) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Self-checking bench for dram_access_arbiter: directed scenarios plus random traffic,
// all compared against a transaction-level model of the arbitration rules.
module tb_dram_access_arbiter;
    localparam int AW = 39;
    localparam int TO = 16;
    localparam logic [AW-1:0] MASK = ~AW'(15);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req_en, rd_urgent, wr_req_en, clear_err;
    logic [AW-1:0] rd_req_addr, wr_req_addr;
    logic [7:0]    rd_req_len, wr_req_len;
    logic          rd_busy, wr_busy, req_drop_err, timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dram_access_arbiter_if #(.DRAM_ADDR_WIDTH(AW)) bus ();

    dram_access_arbiter #(
        .DRAM_ADDR_WIDTH(AW),
        .DRAM_DATA_WIDTH(128),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .rd_req_en    (rd_req_en),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_urgent    (rd_urgent),
        .rd_busy      (rd_busy),
        .wr_req_en    (wr_req_en),
        .wr_req_addr  (wr_req_addr),
        .wr_req_len   (wr_req_len),
        .wr_busy      (wr_busy),
        .cmd          (bus),
        .clear_err    (clear_err),
        .req_drop_err (req_drop_err),
        .timeout_err  (timeout_err)
    );

    // Model: index 0 = write requester, 1 = read requester.
    bit            m_pv[2];
    logic [AW-1:0] m_pa[2];
    logic [7:0]    m_pl[2];
    int            m_phase;  // 0 no burst, 1 offering command, 2 awaiting completion
    int            m_cur, m_last, m_wait;
    bit            m_drop, m_to;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;

    bit            acc_rnw[$];
    logic [AW-1:0] acc_addr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            m_pv[x] = 0;
            m_pa[x] = '0;
            m_pl[x] = '0;
        end
        m_phase = 0; m_cur = 0; m_last = 0; m_wait = 0;
        m_drop = 0; m_to = 0; m_addr = '0; m_len = '0;
    endtask

    function automatic bit m_busy(input int x);
        return m_pv[x] || (m_phase != 0 && m_cur == x);
    endfunction

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_step();
        bit b_old[2];
        bit en[2];
        logic [AW-1:0] a_in[2];
        logic [7:0] l_in[2];
        bit new_drop = 0;
        bit new_to = 0;
        int sel;
        for (int x = 0; x < 2; x++) b_old[x] = m_busy(x);
        en[0] = wr_req_en; en[1] = rd_req_en;
        a_in[0] = wr_req_addr; a_in[1] = rd_req_addr;
        l_in[0] = wr_req_len; l_in[1] = rd_req_len;
        case (m_phase)
            0: if (m_pv[0] || m_pv[1]) begin
                if (m_pv[0] && m_pv[1]) sel = rd_urgent ? 1 : 1 - m_last;
                else sel = m_pv[1] ? 1 : 0;
                m_cur = sel; m_last = sel;
                m_addr = m_pa[sel] & MASK; m_len = m_pl[sel];
                m_pv[sel] = 0; m_phase = 1;
            end
            1: if (bus.cmd_ready) begin m_phase = 2; m_wait = 0; end
            default: begin
                if (bus.cmd_done) m_phase = 0;
                else if (m_wait == TO - 1) begin m_phase = 0; new_to = 1; end
                else m_wait++;
            end
        endcase
        for (int x = 0; x < 2; x++) begin
            if (en[x]) begin
                if (!b_old[x]) begin
                    m_pv[x] = 1; m_pa[x] = a_in[x]; m_pl[x] = l_in[x];
                end else begin
                    new_drop = 1;
                end
            end
        end
        if (new_drop) m_drop = 1; else if (clear_err) m_drop = 0;
        if (new_to) m_to = 1; else if (clear_err) m_to = 0;
    endtask

    task automatic compare_all();
        check("cmd_valid", 64'(bus.cmd_valid), 64'(m_phase == 1));
        if (m_phase == 1) begin
            check("cmd_rnw", 64'(bus.cmd_rnw), 64'(m_cur));
            check("cmd_addr", 64'(bus.cmd_addr), 64'(m_addr));
            check("cmd_len", 64'(bus.cmd_len), 64'(m_len));
        end
        check("rd_busy", 64'(rd_busy), 64'(m_busy(1)));
        check("wr_busy", 64'(wr_busy), 64'(m_busy(0)));
        check("req_drop_err", 64'(req_drop_err), 64'(m_drop));
        check("timeout_err", 64'(timeout_err), 64'(m_to));
    endtask

    // One clock: log any handshake happening now, then step and compare after the edge.
    task automatic cycle();
        if (bus.cmd_valid && bus.cmd_ready) begin
            acc_rnw.push_back(bus.cmd_rnw);
            acc_addr.push_back(bus.cmd_addr);
        end
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic idle_inputs();
        rd_req_en = 0; wr_req_en = 0; rd_urgent = 0; clear_err = 0;
        bus.cmd_ready = 0; bus.cmd_done = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        acc_rnw.delete();
        acc_addr.delete();
    endtask

    // Complete all outstanding work, answering each burst with cmd_done.
    task automatic drain();
        int n = 0;
        bus.cmd_ready = 1;
        while ((m_pv[0] || m_pv[1] || m_phase != 0) && n < 200) begin
            bus.cmd_done = (m_phase == 2);
            cycle();
            n++;
        end
        bus.cmd_done = 0;
        if (n >= 200) check("drain_bound", 64'(n), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        rd_req_addr = '0; wr_req_addr = '0; rd_req_len = '0; wr_req_len = '0;
        idle_inputs();
        do_reset();

        // Reset state.
        check("rst_cmd_valid", 64'(bus.cmd_valid), 64'(0));
        check("rst_rd_busy", 64'(rd_busy), 64'(0));
        check("rst_wr_busy", 64'(wr_busy), 64'(0));
        check("rst_errs", 64'({req_drop_err, timeout_err}), 64'(0));

        // Single write: two-cycle latency, completion clears busy next cycle.
        bus.cmd_ready = 1;
        wr_req_en = 1; wr_req_addr = AW'(64'h1000); wr_req_len = 8'd7;
        cycle();
        wr_req_en = 0;
        check("t1_c1_valid", 64'(bus.cmd_valid), 64'(0));
        cycle();
        check("t1_c2_valid", 64'(bus.cmd_valid), 64'(1));
        check("t1_rnw", 64'(bus.cmd_rnw), 64'(0));
        check("t1_addr", 64'(bus.cmd_addr), 64'h1000);
        check("t1_len", 64'(bus.cmd_len), 64'(7));
        repeat (9) cycle();
        check("t1_busy_hold", 64'(wr_busy), 64'(1));
        bus.cmd_done = 1;
        cycle();
        bus.cmd_done = 0;
        check("t1_busy_fall", 64'(wr_busy), 64'(0));

        // Simultaneous requests alternate R,W,R,W... starting with read.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            rd_req_en = 1; wr_req_en = 1;
            rd_req_addr = AW'({$urandom(), $urandom()});
            wr_req_addr = AW'({$urandom(), $urandom()});
            rd_req_len = 8'($urandom()); wr_req_len = 8'($urandom());
            cycle();
            rd_req_en = 0; wr_req_en = 0;
            drain();
        end
        check("t2_count", 64'(acc_rnw.size()), 64'(8));
        for (int i = 0; i < acc_rnw.size(); i++) check("t2_order", 64'(acc_rnw[i]), 64'(i % 2 == 0));

        // Urgent read wins even after a read grant; write waits for read completion.
        do_reset();
        rd_req_en = 1; rd_req_addr = AW'(64'h2000);
        cycle();
        rd_req_en = 0;
        drain();
        acc_rnw.delete();
        rd_req_en = 1; wr_req_en = 1; rd_urgent = 1; bus.cmd_ready = 1;
        cycle();
        rd_req_en = 0; wr_req_en = 0;
        repeat (8) cycle();
        check("t3_count", 64'(acc_rnw.size()), 64'(1));
        if (acc_rnw.size() >= 1) check("t3_first_read", 64'(acc_rnw[0]), 64'(1));
        check("t3_wr_waits", 64'(wr_busy), 64'(1));
        rd_urgent = 0;
        drain();
        check("t3_count2", 64'(acc_rnw.size()), 64'(2));
        if (acc_rnw.size() >= 2) check("t3_then_write", 64'(acc_rnw[1]), 64'(0));

        // Command held stable while cmd_ready stays low.
        do_reset();
        wr_req_en = 1; wr_req_addr = AW'(64'h12345); wr_req_len = 8'h3c;
        cycle();
        wr_req_en = 0;
        cycle();
        for (int i = 0; i < 20; i++) begin
            check("t4_valid", 64'(bus.cmd_valid), 64'(1));
            check("t4_addr", 64'(bus.cmd_addr), 64'h12340);
            check("t4_len", 64'(bus.cmd_len), 64'h3c);
            check("t4_rnw", 64'(bus.cmd_rnw), 64'(0));
            if (i == 19) bus.cmd_ready = 1;
            cycle();
        end
        check("t4_accepted", 64'(bus.cmd_valid), 64'(0));
        drain();

        // Request while busy is dropped and flagged; clear_err clears the flag.
        do_reset();
        wr_req_en = 1; wr_req_addr = AW'(64'hA000); wr_req_len = 8'd3;
        cycle();
        wr_req_addr = AW'(64'hB000); wr_req_len = 8'd9;
        cycle();
        wr_req_en = 0;
        check("t5_drop_set", 64'(req_drop_err), 64'(1));
        drain();
        check("t5_acc_count", 64'(acc_addr.size()), 64'(1));
        if (acc_addr.size() >= 1) check("t5_addr_kept", 64'(acc_addr[0]), 64'hA000);
        check("t5_drop_sticky", 64'(req_drop_err), 64'(1));
        clear_err = 1;
        cycle();
        clear_err = 0;
        check("t5_drop_clear", 64'(req_drop_err), 64'(0));

        // Missing cmd_done times out, then the pending read is issued.
        do_reset();
        bus.cmd_ready = 1;
        wr_req_en = 1; wr_req_addr = AW'(64'h4000);
        cycle();
        wr_req_en = 0;
        cycle();
        rd_req_en = 1; rd_req_addr = AW'(64'h5000); rd_req_len = 8'd1;
        cycle();
        rd_req_en = 0;
        for (int n = 0; n < 60 && !timeout_err; n++) cycle();
        check("t6_timeout", 64'(timeout_err), 64'(1));
        check("t6_wr_free", 64'(wr_busy), 64'(0));
        cycle();
        check("t6_rd_issue", 64'({bus.cmd_valid, bus.cmd_rnw}), 64'(3));
        check("t6_rd_addr", 64'(bus.cmd_addr), 64'h5000);
        repeat (3) cycle();
        #2;
        rst_n = 0;
        #1;
        check("t6_async_valid", 64'(bus.cmd_valid), 64'(0));
        check("t6_async_busy", 64'({rd_busy, wr_busy}), 64'(0));
        check("t6_async_cmd", 64'({bus.cmd_rnw, bus.cmd_addr, bus.cmd_len}), 64'(0));
        check("t6_async_errs", 64'({req_drop_err, timeout_err}), 64'(0));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rd_req_en = ($urandom_range(3) == 0);
            wr_req_en = ($urandom_range(3) == 0);
            rd_req_addr = AW'({$urandom(), $urandom()});
            wr_req_addr = AW'({$urandom(), $urandom()});
            rd_req_len = 8'($urandom());
            wr_req_len = 8'($urandom());
            rd_urgent = 1'($urandom());
            clear_err = ($urandom_range(15) == 0);
            bus.cmd_ready = 1'($urandom());
            bus.cmd_done = ($urandom_range(5) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
